// File: rtl/dmem_pkg.sv
// Shared encodings and the alignment rule for the data memory sequencer.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic PORT_P = 1'b0;
  localparam logic PORT_L = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  function automatic logic access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way round-robin grant between port P and port L; rr_last lives in the parent.
module dmem_rr_arbiter
  import dmem_pkg::*;
(
  input  logic p_req_i,
  input  logic l_req_i,
  input  logic rr_last_i,
  output logic gnt_valid_o,
  output logic gnt_port_o
);

  always_comb begin
    gnt_valid_o = p_req_i | l_req_i;
    gnt_port_o  = PORT_P;
    if (l_req_i && (!p_req_i || rr_last_i == PORT_P)) gnt_port_o = PORT_L;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Arbitrating sequencer in front of the byte-addressed data memory.
// Optional access statistics counters are enabled by defining DMEM_STATS_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_rw,
  input  logic [1:0]        p_size,
  input  logic              p_sign,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_ack,
  input  logic              l_req,
  input  logic              l_rw,
  input  logic [1:0]        l_size,
  input  logic              l_sign,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic              mem_sign,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       stat_reads,
  output logic [15:0]       stat_writes,
  output logic [15:0]       stat_errs
`endif
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t              state_q;
  logic                rr_last_q, port_q, rw_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_en_q, mem_rw_q, mem_sign_q;
  logic [1:0]          mem_size_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                p_ack_q, l_ack_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic                gnt_valid, gnt_port;
  logic                sel_rw, sel_sign;
  logic [1:0]          sel_size;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  dmem_rr_arbiter u_arb (
    .p_req_i    (p_req),
    .l_req_i    (l_req),
    .rr_last_i  (rr_last_q),
    .gnt_valid_o(gnt_valid),
    .gnt_port_o (gnt_port)
  );

  always_comb begin
    sel_rw    = (gnt_port == PORT_P) ? p_rw    : l_rw;
    sel_size  = (gnt_port == PORT_P) ? p_size  : l_size;
    sel_sign  = (gnt_port == PORT_P) ? p_sign  : l_sign;
    sel_addr  = (gnt_port == PORT_P) ? p_addr  : l_addr;
    sel_wdata = (gnt_port == PORT_P) ? p_wdata : l_wdata;
  end

  // The mem_* registers double as the latched request; they are loaded only for
  // legal accesses and cleared on leaving ACCESS, so they read 0 everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_last_q   <= PORT_L;
      port_q      <= PORT_P;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_sign_q  <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p_ack_q     <= 1'b0;
      l_ack_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            port_q <= gnt_port;
            rw_q   <= sel_rw;
            if (access_ok(sel_size, sel_addr[1:0])) begin
              state_q     <= S_ACCESS;
              cnt_q       <= CNT_W'(WAIT_CYCLES - 1);
              mem_en_q    <= 1'b1;
              mem_rw_q    <= sel_rw;
              mem_sign_q  <= sel_sign;
              mem_size_q  <= sel_size;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end else begin
              state_q     <= S_RESP;
              p_ack_q     <= (gnt_port == PORT_P);
              l_ack_q     <= (gnt_port == PORT_L);
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_sign_q  <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p_ack_q     <= (port_q == PORT_P);
            l_ack_q     <= (port_q == PORT_L);
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= rw_q ? '0 : mem_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rr_last_q   <= port_q;
          p_ack_q     <= 1'b0;
          l_ack_q     <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_enable = mem_en_q;
  assign mem_rw     = mem_rw_q;
  assign mem_sign   = mem_sign_q;
  assign mem_size   = mem_size_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign p_ack      = p_ack_q;
  assign l_ack      = l_ack_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;

`ifdef DMEM_STATS_EN
  logic [15:0] st_reads_q, st_writes_q, st_errs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_reads_q  <= '0;
      st_writes_q <= '0;
      st_errs_q   <= '0;
    end else if (state_q == S_RESP) begin
      if (rsp_err_q) begin
        if (st_errs_q != '1) st_errs_q <= st_errs_q + 16'd1;
      end else if (rw_q) begin
        if (st_writes_q != '1) st_writes_q <= st_writes_q + 16'd1;
      end else begin
        if (st_reads_q != '1) st_reads_q <= st_reads_q + 16'd1;
      end
    end
  end

  assign stat_reads  = st_reads_q;
  assign stat_writes = st_writes_q;
  assign stat_errs   = st_errs_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: timeline model for WAIT_CYCLES=1, directed reset test for WAIT_CYCLES=3.
module tb_data_mem_ctrl;

  localparam int W1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- DUT 1 (WAIT_CYCLES=1) ----------------
  logic        rst1;
  logic        p_req, p_rw, p_sign, l_req, l_rw, l_sign;
  logic [1:0]  p_size, l_size;
  logic [7:0]  p_addr, l_addr;
  logic [31:0] p_wdata, l_wdata;
  logic        p_ack, l_ack, mem_enable, mem_rw, mem_sign, rsp_err;
  logic [1:0]  mem_size;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rsp_rdata;
`ifdef DMEM_STATS_EN
  logic [15:0] st_r, st_w, st_e, st_r3, st_w3, st_e3;
`endif

  data_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(rst1),
    .p_req(p_req), .p_rw(p_rw), .p_size(p_size), .p_sign(p_sign), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_ack(p_ack),
    .l_req(l_req), .l_rw(l_rw), .l_size(l_size), .l_sign(l_sign), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_ack(l_ack),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_sign(mem_sign), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
    , .stat_reads(st_r), .stat_writes(st_w), .stat_errs(st_e)
`endif
  );

  function automatic logic [31:0] rd_val(input logic [7:0] b0, b1, b2, b3,
                                         input logic [1:0] sz, input logic sg);
    case (sz)
      2'b00:   return {{24{sg & b0[7]}}, b0};
      2'b01:   return {{16{sg & b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // Little-endian byte memory attached to DUT 1.
  logic [7:0] dev[256];
  logic [7:0] a1, a2, a3;
  assign a1 = mem_addr + 8'd1;
  assign a2 = mem_addr + 8'd2;
  assign a3 = mem_addr + 8'd3;
  assign mem_rdata = (mem_enable && !mem_rw) ?
                     rd_val(dev[mem_addr], dev[a1], dev[a2], dev[a3], mem_size, mem_sign) : '0;
  always @(posedge clk) begin
    if (mem_enable && mem_rw) begin
      dev[mem_addr] <= mem_wdata[7:0];
      if (mem_size != 2'b00) dev[a1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        dev[a2] <= mem_wdata[23:16];
        dev[a3] <= mem_wdata[31:24];
      end
    end
  end

  // ---------------- Behavioural model (timeline view) ----------------
  logic [7:0]  ref_mem[256];
  bit          m_busy, m_port, m_err, m_rw, m_sign, m_rr_last;
  int          m_ph, m_ackph, m_reads, m_writes, m_errs;
  logic [1:0]  m_size;
  logic [7:0]  m_addr, r1, r2, r3;
  logic [31:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (rst1) begin
      m_busy = 0; m_rr_last = 1; m_ph = 0; m_ackph = 0;
      m_reads = 0; m_writes = 0; m_errs = 0;
    end else if (m_busy) begin
      if (m_ph == m_ackph) begin
        m_busy = 0;
        if (m_err) m_errs++;
        else if (m_rw) m_writes++;
        else m_reads++;
      end else m_ph++;
    end else if (p_req || l_req) begin
      m_port = (p_req && (!l_req || m_rr_last)) ? 1'b0 : 1'b1;
      m_rr_last = m_port;
      m_rw    = m_port ? l_rw    : p_rw;
      m_size  = m_port ? l_size  : p_size;
      m_sign  = m_port ? l_sign  : p_sign;
      m_addr  = m_port ? l_addr  : p_addr;
      m_wdata = m_port ? l_wdata : p_wdata;
      m_err = (m_size == 2'b11) || (m_size == 2'b01 && m_addr[0]) ||
              (m_size == 2'b10 && m_addr[1:0] != 2'b00);
      m_ackph = m_err ? 1 : W1 + 1;
      m_ph = 1;
      m_busy = 1;
      r1 = m_addr + 8'd1; r2 = m_addr + 8'd2; r3 = m_addr + 8'd3;
      m_rdata = '0;
      if (!m_err && m_rw) begin
        ref_mem[m_addr] = m_wdata[7:0];
        if (m_size != 2'b00) ref_mem[r1] = m_wdata[15:8];
        if (m_size == 2'b10) begin ref_mem[r2] = m_wdata[23:16]; ref_mem[r3] = m_wdata[31:24]; end
      end else if (!m_err) begin
        m_rdata = rd_val(ref_mem[m_addr], ref_mem[r1], ref_mem[r2], ref_mem[r3], m_size, m_sign);
      end
    end
  end

  bit ack_log[$];
  logic e_en, e_ack;

  always @(negedge clk) begin
    if (!rst1) begin
      e_en  = m_busy && !m_err && (m_ph <= W1);
      e_ack = m_busy && (m_ph == m_ackph);
      chk("p_ack", p_ack, e_ack && !m_port);
      chk("l_ack", l_ack, e_ack && m_port);
      chk("mem_enable", mem_enable, e_en);
      chk("mem_rw", mem_rw, e_en && m_rw);
      chk("mem_sign", mem_sign, e_en && m_sign);
      chk("mem_size", mem_size, e_en ? m_size : 2'b00);
      chk("mem_addr", mem_addr, e_en ? m_addr : 8'h00);
      chk("mem_wdata", mem_wdata, e_en ? m_wdata : 32'h0);
      if (e_ack) begin
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_rdata", rsp_rdata, m_rdata);
      end
`ifdef DMEM_STATS_EN
      chk("stat_reads", st_r, m_reads);
      chk("stat_writes", st_w, m_writes);
      chk("stat_errs", st_e, m_errs);
`endif
      if (p_ack) ack_log.push_back(1'b0);
      if (l_ack) ack_log.push_back(1'b1);
    end
  end

  // ---------------- DUT 3 (WAIT_CYCLES=3) ----------------
  logic        rst3, p_req3, p_rw3, p_sign3, p_ack3, l_ack3;
  logic [1:0]  p_size3, mem_size3;
  logic [7:0]  p_addr3, mem_addr3;
  logic [31:0] p_wdata3, mem_wdata3, mem_rdata3, rsp_rdata3;
  logic        mem_enable3, mem_rw3, mem_sign3, rsp_err3;
  logic        l_req3 = 1'b0, l_rw3 = 1'b0, l_sign3 = 1'b0;
  logic [1:0]  l_size3 = 2'b00;
  logic [7:0]  l_addr3 = 8'h00;
  logic [31:0] l_wdata3 = 32'h0;
  int          ack3_cnt = 0;

  data_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst3),
    .p_req(p_req3), .p_rw(p_rw3), .p_size(p_size3), .p_sign(p_sign3), .p_addr(p_addr3),
    .p_wdata(p_wdata3), .p_ack(p_ack3),
    .l_req(l_req3), .l_rw(l_rw3), .l_size(l_size3), .l_sign(l_sign3), .l_addr(l_addr3),
    .l_wdata(l_wdata3), .l_ack(l_ack3),
    .mem_enable(mem_enable3), .mem_rw(mem_rw3), .mem_sign(mem_sign3), .mem_size(mem_size3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
`ifdef DMEM_STATS_EN
    , .stat_reads(st_r3), .stat_writes(st_w3), .stat_errs(st_e3)
`endif
  );

  assign mem_rdata3 = mem_enable3 ? {mem_addr3, ~mem_addr3, mem_addr3 ^ 8'h5A, 8'hC3} : '0;
  always @(negedge clk) if (p_ack3) ack3_cnt++;

  // ---------------- Directed stimulus ----------------
  task automatic acc(input bit port, input bit rw, input logic [1:0] sz, input bit sg,
                     input logic [7:0] ad, input logic [31:0] wd, input int exp_lat,
                     output logic [31:0] rd, output logic er);
    int lat, en_cnt;
    bit got;
    @(negedge clk);
    if (!port) begin p_req = 1; p_rw = rw; p_size = sz; p_sign = sg; p_addr = ad; p_wdata = wd; end
    else       begin l_req = 1; l_rw = rw; l_size = sz; l_sign = sg; l_addr = ad; l_wdata = wd; end
    lat = 0; en_cnt = 0; got = 0; rd = '0; er = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mem_enable) en_cnt++;
      if (port ? l_ack : p_ack) begin got = 1; rd = rsp_rdata; er = rsp_err; end
    end
    chk("ack_latency", lat, exp_lat);
    chk("enable_cycles", en_cnt, (exp_lat == 1) ? 0 : W1);
    @(negedge clk);
    p_req = 0; l_req = 0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat3, en3;
  bit          got3;

  initial begin
    rst1 = 1; rst3 = 1;
    p_req = 0; p_rw = 0; p_size = 0; p_sign = 0; p_addr = 0; p_wdata = 0;
    l_req = 0; l_rw = 0; l_size = 0; l_sign = 0; l_addr = 0; l_wdata = 0;
    p_req3 = 0; p_rw3 = 0; p_size3 = 0; p_sign3 = 0; p_addr3 = 0; p_wdata3 = 0;
    for (int i = 0; i < 256; i++) begin dev[i] = 8'h00; ref_mem[i] = 8'h00; end
    repeat (3) @(negedge clk);
    chk("rst_p_ack", p_ack, 0);
    chk("rst_l_ack", l_ack, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst3_mem_enable", mem_enable3, 0);
`ifdef DMEM_STATS_EN
    chk("rst_stat_reads", st_r, 0);
`endif
    rst1 = 0; rst3 = 0;

    // Word write/read-back
    acc(0, 1, 2'b10, 0, 8'h10, 32'hDEADBEEF, 2, rd, er);
    chk("wr_word_err", er, 0);
    acc(0, 0, 2'b10, 0, 8'h10, 32'h0, 2, rd, er);
    chk("rd_word_data", rd, 32'hDEADBEEF);
    chk("rd_word_err", er, 0);

    // Byte with and without sign extension, half from port L
    acc(0, 1, 2'b00, 0, 8'h21, 32'h00000080, 2, rd, er);
    acc(0, 0, 2'b00, 1, 8'h21, 32'h0, 2, rd, er);
    chk("rd_byte_sx", rd, 32'hFFFFFF80);
    acc(0, 0, 2'b00, 0, 8'h21, 32'h0, 2, rd, er);
    chk("rd_byte_zx", rd, 32'h00000080);
    acc(1, 1, 2'b01, 0, 8'h30, 32'h00008001, 2, rd, er);
    acc(0, 0, 2'b01, 1, 8'h30, 32'h0, 2, rd, er);
    chk("rd_half_sx", rd, 32'hFFFF8001);
    acc(1, 1, 2'b10, 0, 8'hFC, 32'h01234567, 2, rd, er);
    acc(1, 0, 2'b10, 0, 8'hFC, 32'h0, 2, rd, er);
    chk("rd_word_top", rd, 32'h01234567);

    // Rejected accesses
    acc(0, 0, 2'b01, 0, 8'h03, 32'h0, 1, rd, er);
    chk("err_half_mis", er, 1);
    chk("err_half_data", rd, 0);
    acc(1, 0, 2'b10, 0, 8'h02, 32'h0, 1, rd, er);
    chk("err_word_mis", er, 1);
    acc(0, 1, 2'b11, 0, 8'h00, 32'h12345678, 1, rd, er);
    chk("err_size_ill", er, 1);

    // Both ports held continuously from reset
    @(negedge clk); rst1 = 1;
    p_rw = 0; p_size = 2'b10; p_sign = 0; p_addr = 8'h10; p_wdata = 0;
    l_rw = 0; l_size = 2'b00; l_sign = 1; l_addr = 8'h21; l_wdata = 0;
    p_req = 1; l_req = 1;
    @(negedge clk); ack_log.delete(); rst1 = 0;
    repeat (19) @(negedge clk);
    p_req = 0; l_req = 0;
    repeat (4) @(negedge clk);
    chk("rr_ack_count_ge6", (ack_log.size() >= 6), 1);
    if (ack_log.size() >= 6)
      for (int i = 0; i < 6; i++) chk("rr_order", ack_log[i], i % 2);

    // Traffic mix after reset (statistics)
    @(negedge clk); rst1 = 1;
    @(negedge clk); rst1 = 0;
    acc(0, 1, 2'b10, 0, 8'h40, 32'h11112222, 2, rd, er);
    acc(1, 1, 2'b00, 0, 8'h44, 32'h0000007F, 2, rd, er);
    acc(0, 0, 2'b10, 0, 8'h40, 32'h0, 2, rd, er);
    chk("mix_rd_word", rd, 32'h11112222);
    acc(1, 0, 2'b00, 1, 8'h44, 32'h0, 2, rd, er);
    chk("mix_rd_byte", rd, 32'h0000007F);
    acc(0, 0, 2'b01, 0, 8'h40, 32'h0, 2, rd, er);
    chk("mix_rd_half", rd, 32'h00002222);
    acc(1, 0, 2'b10, 0, 8'h41, 32'h0, 1, rd, er);
    chk("mix_err", er, 1);
    @(negedge clk);
`ifdef DMEM_STATS_EN
    chk("stats_reads", st_r, 3);
    chk("stats_writes", st_w, 2);
    chk("stats_errs", st_e, 1);
`endif

    // Reset during the second ACCESS cycle of a WAIT_CYCLES=3 read
    @(negedge clk);
    p_req3 = 1; p_rw3 = 0; p_size3 = 2'b10; p_sign3 = 0; p_addr3 = 8'h40;
    @(posedge clk); #1;
    chk("d3_enable_c1", mem_enable3, 1);
    @(posedge clk); #1;
    chk("d3_enable_c2", mem_enable3, 1);
    rst3 = 1; p_req3 = 0;
    #1;
    chk("d3_rst_enable", mem_enable3, 0);
    chk("d3_rst_addr", mem_addr3, 0);
    chk("d3_rst_size", mem_size3, 0);
    chk("d3_rst_ack", p_ack3, 0);
    repeat (2) @(negedge clk);
    rst3 = 0;
    repeat (5) @(negedge clk);
    chk("d3_no_ack", ack3_cnt, 0);
    p_req3 = 1; p_addr3 = 8'h44;
    lat3 = 0; en3 = 0; got3 = 0;
    while (!got3 && lat3 < 20) begin
      @(posedge clk); #1;
      lat3++;
      if (mem_enable3) en3++;
      if (p_ack3) begin
        got3 = 1;
        chk("d3_rdata", rsp_rdata3, 32'h44BB1EC3);
        chk("d3_err", rsp_err3, 0);
      end
    end
    chk("d3_latency", lat3, 4);
    chk("d3_enable_cycles", en3, 3);
    @(negedge clk); p_req3 = 0;
    repeat (3) @(negedge clk);
    chk("d3_ack_total", ack3_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
